iiitb_4bbc_sweep_ctrl: RTL and testbench

Bounce-sweep sequencer for the 4-bit up/down counter. On a start request it loads the counter with a lower bound and counts up to an upper bound. It then reverses, counts back down to the lower bound, and repeats for a programmed number of sweeps. It owns the counter's direction and enable, and gives the rest of the design a start/busy/done handshake in place of raw up/down control.

---
 rtl/iiitb_4bbc_pkg.sv | 17 +
 rtl/iiitb_4bbc_updn.sv | 38 +++
 rtl/iiitb_4bbc_sweep_ctrl.sv | 144 ++++++++++++++
 tb/tb_iiitb_4bbc_sweep_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/iiitb_4bbc_pkg.sv
// rtl/iiitb_4bbc_pkg.sv - shared types and constants for the 4-bit bounce-sweep counter
package iiitb_4bbc_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int NW_DEF    = 4;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DONE = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/iiitb_4bbc_updn.sv
// rtl/iiitb_4bbc_updn.sv - WIDTH-bit up/down counter with enable and synchronous load
module iiitb_4bbc_updn
    import iiitb_4bbc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_or_down,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = (up_or_down == DIR_DOWN) ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/iiitb_4bbc_sweep_ctrl.sv
// rtl/iiitb_4bbc_sweep_ctrl.sv - start/busy/done sequencer bouncing the counter between captured bounds
module iiitb_4bbc_sweep_ctrl
    import iiitb_4bbc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NW    = NW_DEF
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [NW-1:0]    n_sweeps,
    output logic [WIDTH-1:0] Count,
    output logic             UpOrDown,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [NW-1:0]    sweeps_left
);

    sweep_state_e     state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [NW-1:0]    sweeps_q, sweeps_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             cnt_en;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_val;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] cnt_dec;

    assign cnt_inc = Count + WIDTH'(1);
    assign cnt_dec = Count - WIDTH'(1);

    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        sweeps_d     = sweeps_q;
        dir_d        = dir_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        cnt_en       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = lo;

        // abort freezes the counter where it stands and drops straight to idle
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if ((lo < hi) && (n_sweeps != '0)) begin
                            lo_d     = lo;
                            hi_d     = hi;
                            sweeps_d = n_sweeps;
                            cnt_load = 1'b1;
                            dir_d    = DIR_UP;
                            state_d  = ST_UP;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_UP: begin
                    cnt_en = 1'b1;
                    if (cnt_inc == hi_q) begin
                        dir_d   = DIR_DOWN;
                        state_d = ST_DOWN;
                    end
                end
                ST_DOWN: begin
                    cnt_en = 1'b1;
                    if (cnt_dec == lo_q) begin
                        sweeps_d = sweeps_q - NW'(1);
                        if (sweeps_q == NW'(1)) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            dir_d   = DIR_UP;
                            state_d = ST_UP;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_UP) || (state_d == ST_DOWN);
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            sweeps_q <= '0;
            dir_q    <= DIR_UP;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            sweeps_q <= sweeps_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    iiitb_4bbc_updn #(
        .WIDTH (WIDTH)
    ) u_updn (
        .clk        (Clk),
        .rst_n      (reset),
        .en         (cnt_en),
        .load       (cnt_load),
        .load_val   (cnt_load_val),
        .up_or_down (dir_q),
        .count      (Count)
    );

    assign UpOrDown    = dir_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign sweeps_left = sweeps_q;

endmodule

// File: tb/tb_iiitb_4bbc_sweep_ctrl.sv
// tb/tb_iiitb_4bbc_sweep_ctrl.sv - directed self-checking bench for the bounce-sweep sequencer
module tb_iiitb_4bbc_sweep_ctrl;

    logic       Clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] n_sweeps;
    logic [3:0] Count;
    logic       UpOrDown;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] sweeps_left;

    int checks   = 0;
    int failures = 0;

    iiitb_4bbc_sweep_ctrl #(
        .WIDTH (4),
        .NW    (4)
    ) dut (
        .Clk         (Clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .lo          (lo),
        .hi          (hi),
        .n_sweeps    (n_sweeps),
        .Count       (Count),
        .UpOrDown    (UpOrDown),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .sweeps_left (sweeps_left)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    int exp_cnt [9];
    int exp_dir [9];
    int exp_swp [9];
    int exp_cf;

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        lo       = 4'd0;
        hi       = 4'd0;
        n_sweeps = 4'd0;
        #12;
        check("rst_count", Count, 0);
        check("rst_dir", UpOrDown, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_sweeps", sweeps_left, 0);
        reset = 1'b1;
        tick();

        // basic run lo=2 hi=4 n=2
        exp_cnt = '{2, 3, 4, 3, 2, 3, 4, 3, 2};
        exp_dir = '{0, 0, 1, 1, 0, 0, 1, 1, 1};
        exp_swp = '{2, 2, 2, 2, 1, 1, 1, 1, 0};
        lo = 4'd2; hi = 4'd4; n_sweeps = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i != 0) tick();
            check($sformatf("basic_count[%0d]", i), Count, exp_cnt[i]);
            check($sformatf("basic_dir[%0d]", i), UpOrDown, exp_dir[i]);
            check($sformatf("basic_sweeps[%0d]", i), sweeps_left, exp_swp[i]);
            check($sformatf("basic_busy[%0d]", i), busy, (i < 8) ? 1 : 0);
            check($sformatf("basic_done[%0d]", i), done, (i == 8) ? 1 : 0);
        end
        tick();
        check("basic_done_clear", done, 0);
        check("basic_idle_busy", busy, 0);
        check("basic_idle_count", Count, 2);

        // full range lo=0 hi=15 n=1
        lo = 4'd0; hi = 4'd15; n_sweeps = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("full_count0", Count, 0);
        check("full_busy0", busy, 1);
        for (int i = 1; i <= 30; i++) begin
            tick();
            exp_cf = (i <= 15) ? i : 30 - i;
            check($sformatf("full_count[%0d]", i), Count, exp_cf);
            check($sformatf("full_done[%0d]", i), done, (i == 30) ? 1 : 0);
            check($sformatf("full_busy[%0d]", i), busy, (i < 30) ? 1 : 0);
        end
        tick();

        // rejected starts
        lo = 4'd5; hi = 4'd5; n_sweeps = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        check("rej_eq_err", err, 1);
        check("rej_eq_busy", busy, 0);
        check("rej_eq_count", Count, 0);
        check("rej_eq_sweeps", sweeps_left, 0);
        tick();
        check("rej_eq_err_clear", err, 0);
        lo = 4'd6; hi = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check("rej_inv_err", err, 1);
        check("rej_inv_busy", busy, 0);
        tick();
        lo = 4'd1; hi = 4'd5; n_sweeps = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("rej_n0_err", err, 1);
        check("rej_n0_busy", busy, 0);
        check("rej_n0_count", Count, 0);
        tick();

        // abort in DOWN at Count=6
        lo = 4'd1; hi = 4'd9; n_sweeps = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check("ab_accept_count", Count, 1);
        for (int i = 0; i < 11; i++) tick();
        check("ab_pre_count", Count, 6);
        check("ab_pre_dir", UpOrDown, 1);
        abort = 1'b1; start = 1'b1; lo = 4'd3; hi = 4'd5; n_sweeps = 4'd1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_count", Count, 6);
        check("ab_dir", UpOrDown, 1);
        check("ab_sweeps", sweeps_left, 3);
        check("ab_done", done, 0);
        check("ab_err", err, 0);
        tick();
        check("ab_idle_count", Count, 6);
        check("ab_idle_busy", busy, 0);
        check("ab_idle_done", done, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ab_restart_count", Count, 3);
        check("ab_restart_busy", busy, 1);
        check("ab_restart_dir", UpOrDown, 0);
        check("ab_restart_sweeps", sweeps_left, 1);
        for (int i = 0; i < 4; i++) tick();
        check("ab_restart_done", done, 1);
        tick();

        // start held high, bounds changed mid-run
        lo = 4'd2; hi = 4'd4; n_sweeps = 4'd1; start = 1'b1;
        tick();
        check("held_count0", Count, 2);
        tick();
        lo = 4'd0; hi = 4'd9; n_sweeps = 4'd2;
        check("held_count1", Count, 3);
        tick();
        check("held_count2", Count, 4);
        check("held_dir2", UpOrDown, 1);
        tick();
        check("held_count3", Count, 3);
        tick();
        check("held_done", done, 1);
        check("held_done_count", Count, 2);
        check("held_done_busy", busy, 0);
        tick();
        check("held_gap_busy", busy, 0);
        check("held_gap_count", Count, 2);
        tick();
        check("held_rerun_busy", busy, 1);
        check("held_rerun_count", Count, 0);
        check("held_rerun_sweeps", sweeps_left, 2);
        start = 1'b0;
        tick();
        check("held_rerun_count1", Count, 1);

        // async reset between edges
        #2;
        reset = 1'b0;
        #1;
        check("arst_count", Count, 0);
        check("arst_busy", busy, 0);
        check("arst_dir", UpOrDown, 0);
        check("arst_sweeps", sweeps_left, 0);
        check("arst_done", done, 0);
        tick();
        reset = 1'b1;
        lo = 4'd0; hi = 4'd1; n_sweeps = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("post_count0", Count, 0);
        check("post_busy0", busy, 1);
        tick();
        check("post_count1", Count, 1);
        check("post_dir1", UpOrDown, 1);
        tick();
        check("post_count2", Count, 0);
        check("post_done", done, 1);
        check("post_busy2", busy, 0);
        tick();
        check("post_done_clear", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
